// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rx, 16x oversampled, one mid-bit sample per bit.
// Delivers each word on dout with a one-clk rx_done_tick and a coincident frame_err on a low stop bit.
module uart_rx #(
    parameter int DATA_SIZE      = 8,
    parameter int SAMPLE         = 16,
    parameter int TICK_CNT_SIZE  = $clog2(SAMPLE),
    parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 rx_done_tick,
    output logic                 frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [TICK_CNT_SIZE-1:0]  HALF_TICK = TICK_CNT_SIZE'(SAMPLE / 2 - 1);
    localparam logic [TICK_CNT_SIZE-1:0]  LAST_TICK = TICK_CNT_SIZE'(SAMPLE - 1);
    localparam logic [BIT_COUNT_SIZE-1:0] LAST_BIT  = BIT_COUNT_SIZE'(DATA_SIZE - 1);

    state_t                    state, state_next;
    logic [TICK_CNT_SIZE-1:0]  tick_cnt, tick_next;
    logic [BIT_COUNT_SIZE-1:0] bit_cnt, bit_next;
    logic [DATA_SIZE-1:0]      shift_reg, shift_next;
    logic [DATA_SIZE-1:0]      dout_next;
    logic                      done_next;
    logic                      ferr_next;
    logic                      rx_meta, rx_s, rx_d;

    // Sync flops reset high so an idle line never looks like a falling edge after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_next;
            tick_cnt     <= tick_next;
            bit_cnt      <= bit_next;
            shift_reg    <= shift_next;
            dout         <= dout_next;
            rx_done_tick <= done_next;
            frame_err    <= ferr_next;
        end
    end

    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        dout_next  = dout;
        done_next  = 1'b0;
        ferr_next  = 1'b0;

        case (state)
            IDLE: begin
                // Edge-triggered, so a line stuck low cannot start a new frame
                if (rx_d && !rx_s) begin
                    tick_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_cnt == HALF_TICK) begin
                        if (!rx_s) begin
                            tick_next  = '0;
                            bit_next   = '0;
                            state_next = DATA;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        tick_next = tick_cnt + TICK_CNT_SIZE'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        shift_next = {rx_s, shift_reg[DATA_SIZE-1:1]};
                        tick_next  = '0;
                        bit_next   = bit_cnt + BIT_COUNT_SIZE'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state_next = STOP;
                        end
                    end else begin
                        tick_next = tick_cnt + TICK_CNT_SIZE'(1);
                    end
                end
            end
            STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge
                if (s_tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        dout_next  = shift_reg;
                        done_next  = 1'b1;
                        ferr_next  = !rx_s;
                        state_next = IDLE;
                    end else begin
                        tick_next = tick_cnt + TICK_CNT_SIZE'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames at 115200 baud from a 50 MHz clock, checked by a
// scoreboard of expected words, frame errors and start-edge times.
module tb_uart_rx;

    localparam int DVSR    = 27;
    localparam int BIT_CLK = 16 * DVSR;
    localparam int LAT_NOM = (19 * BIT_CLK) / 2;
    localparam int LAT_LO  = LAT_NOM - 2 * DVSR;
    localparam int LAT_HI  = LAT_NOM + 2 * DVSR;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        int         start_cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   done_count = 0;
    int   cyc        = 0;

    uart_rx #(
        .DATA_SIZE(8),
        .SAMPLE(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_tick(s_tick),
        .rx(rx),
        .dout(dout),
        .rx_done_tick(rx_done_tick),
        .frame_err(frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Free-running sampling tick, one clk wide every DVSR clks
    initial begin
        int tc;
        tc     = 0;
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            s_tick = (tc == DVSR - 1);
            tc     = (tc == DVSR - 1) ? 0 : tc + 1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        exp_t e;
        e.data      = data;
        e.ferr      = !stop;
        e.start_cyc = cyc;
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 2 * 10 * BIT_CLK;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_output("scoreboard_drained", exp_q.size(), 0);
    endtask

    // Monitor: pops one expectation per done pulse and checks pulse widths
    initial begin
        logic prev_done;
        exp_t e;
        int   lat;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done) begin
                check_output("done_one_clk", rx_done_tick, 0);
                check_output("ferr_one_clk", frame_err, 0);
            end
            prev_done = (rx_done_tick === 1'b1);
            if (rx_done_tick === 1'b1) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("[TB] FAIL unexpected_done: observed dout=0x%0h with nothing expected", dout);
                end else begin
                    e   = exp_q.pop_front();
                    lat = cyc - e.start_cyc;
                    check_output("dout", dout, e.data);
                    check_output("frame_err", frame_err, e.ferr);
                    check_output("latency_in_window", (lat >= LAT_LO && lat <= LAT_HI), 1);
                end
            end else if (frame_err !== 1'b0) begin
                checks++;
                failures++;
                $error("[TB] FAIL stray_frame_err: observed=%b expected=0", frame_err);
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check_output("reset_dout", dout, 0);
        check_output("reset_done", rx_done_tick, 0);
        check_output("reset_ferr", frame_err, 0);
        reset = 1'b0;
        idle_bits(1);

        $display("[TB] single frame 0xCB");
        send_frame(8'hCB, 1'b1);
        idle_bits(1);
        wait_drain();

        $display("[TB] back-to-back 0x29, 0xA5");
        send_frame(8'h29, 1'b1);
        send_frame(8'hA5, 1'b1);
        idle_bits(1);
        wait_drain();
        check_output("dout_held_after_b2b", dout, 8'hA5);

        $display("[TB] glitch rejection then 0x5A");
        rx = 1'b0;
        repeat (3 * DVSR) @(negedge clk);
        idle_bits(2);
        check_output("glitch_dout_held", dout, 8'hA5);
        send_frame(8'h5A, 1'b1);
        idle_bits(1);
        wait_drain();

        $display("[TB] framing error 0x55, line low, then 0x3C");
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (2 * BIT_CLK) @(negedge clk);
        idle_bits(2);
        wait_drain();
        check_output("ferr_dout_held", dout, 8'h55);
        send_frame(8'h3C, 1'b1);
        idle_bits(1);
        wait_drain();

        $display("[TB] reset during data bit 4 of 0xF0, then 0x81");
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_output("midframe_reset_dout", dout, 0);
        check_output("midframe_reset_done", rx_done_tick, 0);
        reset = 1'b0;
        repeat (BIT_CLK - 205 + 4 * BIT_CLK) @(negedge clk);
        check_output("aborted_frame_dout", dout, 0);
        send_frame(8'h81, 1'b1);
        idle_bits(1);
        wait_drain();
        check_output("final_dout", dout, 8'h81);
        check_output("done_pulse_count", done_count, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
